pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller: per-stage stall masks,
// exception and eret flush, stall-timeout halt and stall accounting.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        except_valid,
    input  logic [31:0] except_vec,
    input  logic        eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [5:0]  req_mask;
    logic        any_req;
    logic        redir;
    logic        timeout;
    logic [31:0] redir_pc;

    assign any_req  = stallreq_id | stallreq_ex | stallreq_mem;
    // MEM stall blocks redirect capture; the source keeps it asserted.
    assign redir    = (except_valid | eret) & ~stallreq_mem;
    assign redir_pc = except_valid ? except_vec : cp0_epc;
    assign cnt_next = cnt + 32'd1;
    assign timeout  = (cnt_next >= STALL_TIMEOUT);

    always_comb begin
        req_mask = 6'b000000;
        if (stallreq_mem)
            req_mask = 6'b011111;
        else if (stallreq_ex)
            req_mask = 6'b001111;
        else if (stallreq_id)
            req_mask = 6'b000111;
    end

    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            stall = req_mask;
        end else begin
            unique case (state)
                RUN, STALL: stall = req_mask;
                FLUSH:      stall = 6'b000000;
                HALT:       stall = 6'b111111;
                default:    stall = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
            halted       <= 1'b0;
            flush        <= 1'b0;
            new_pc       <= '0;
        end else begin
            if (stall[0] && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;

            unique case (state)
                RUN: begin
                    cnt <= '0;
                    if (redir) begin
                        state  <= FLUSH;
                        flush  <= 1'b1;
                        new_pc <= redir_pc;
                    end else if (any_req) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (redir) begin
                        state  <= FLUSH;
                        flush  <= 1'b1;
                        new_pc <= redir_pc;
                        cnt    <= '0;
                    end else if (!any_req) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (timeout) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                FLUSH: begin
                    state  <= RUN;
                    flush  <= 1'b0;
                    new_pc <= '0;
                    cnt    <= '0;
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                    flush  <= 1'b0;
                    new_pc <= '0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall masks, redirects, flush,
// stall-timeout halt and reset behaviour.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        except_valid;
    logic [31:0] except_vec;
    logic        eret;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        halted;
    logic [31:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.STALL_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .except_valid (except_valid),
        .except_vec   (except_vec),
        .eret         (eret),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] s32(input logic [5:0] s);
        return {26'd0, s};
    endfunction

    initial begin
        rst = 1'b1;
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        except_valid = 0; eret = 0;
        except_vec = '0; cp0_epc = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cycles", stall_cycles, 32'd0);
        check("rst_stall", s32(stall), 32'd0);

        // EX stall for three cycles
        stallreq_ex = 1; #1;
        check("ex_c1", s32(stall), 32'h0F);
        tick();
        check("ex_c2", s32(stall), 32'h0F);
        tick();
        check("ex_c3", s32(stall), 32'h0F);
        tick();
        stallreq_ex = 0; #1;
        check("ex_after", s32(stall), 32'h00);
        check("ex_cycles", stall_cycles, 32'd3);
        tick();
        check("ex_run", s32(stall), 32'h00);

        // id + mem together: mem wins
        stallreq_id = 1; stallreq_mem = 1; #1;
        check("id_mem", s32(stall), 32'h1F);
        tick();
        stallreq_id = 0; stallreq_mem = 0;
        tick();
        check("idmem_cycles", stall_cycles, 32'd4);

        // exception in RUN
        except_valid = 1; except_vec = 32'h20; #1;
        check("exc_pre_flush", {31'd0, flush}, 32'd0);
        tick();
        except_valid = 0; #1;
        check("exc_flush", {31'd0, flush}, 32'd1);
        check("exc_pc", new_pc, 32'h20);
        check("exc_stall", s32(stall), 32'h00);
        tick();
        check("exc_flush_off", {31'd0, flush}, 32'd0);
        check("exc_pc_off", new_pc, 32'd0);

        // exception beats eret
        except_valid = 1; eret = 1; cp0_epc = 32'h1000;
        tick();
        except_valid = 0; eret = 0;
        check("both_flush", {31'd0, flush}, 32'd1);
        check("both_pc", new_pc, 32'h20);
        tick();

        // eret alone
        eret = 1;
        tick();
        eret = 0;
        check("eret_pc", new_pc, 32'h1000);
        tick();

        // exception held off by mem stall
        stallreq_mem = 1; except_valid = 1; except_vec = 32'h44;
        tick();
        check("memblk_1", {31'd0, flush}, 32'd0);
        tick();
        check("memblk_2", {31'd0, flush}, 32'd0);
        stallreq_mem = 0;
        tick();
        except_valid = 0;
        check("memblk_flush", {31'd0, flush}, 32'd1);
        check("memblk_pc", new_pc, 32'h44);

        // inputs ignored while in FLUSH
        stallreq_ex = 1; eret = 1; #1;
        check("flush_stall0", s32(stall), 32'h00);
        tick();
        eret = 0; #1;
        check("postflush_fl", {31'd0, flush}, 32'd0);
        check("postflush_st", s32(stall), 32'h0F);
        stallreq_ex = 0;
        tick();
        tick();

        // reset during FLUSH
        except_valid = 1; except_vec = 32'h80;
        tick();
        except_valid = 0;
        check("rf_flush", {31'd0, flush}, 32'd1);
        rst = 1;
        tick();
        rst = 0; #1;
        check("rf_flush0", {31'd0, flush}, 32'd0);
        check("rf_pc0", new_pc, 32'd0);
        check("rf_cycles", stall_cycles, 32'd0);
        check("rf_stall", s32(stall), 32'd0);

        // stall timeout -> HALT
        stallreq_mem = 1;
        for (int i = 0; i < 4; i++) tick();
        check("to_not_yet", {31'd0, halted}, 32'd0);
        tick();
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_stall", s32(stall), 32'h3F);
        check("to_cycles", stall_cycles, 32'd5);
        stallreq_mem = 0; except_valid = 1;
        tick();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_stall", s32(stall), 32'h3F);
        check("halt_noflush", {31'd0, flush}, 32'd0);
        check("halt_cycles", stall_cycles, 32'd6);
        except_valid = 0;
        rst = 1; #1;
        check("halt_rst_stall", s32(stall), 32'h00);
        tick();
        rst = 0; #1;
        check("hrst_halted", {31'd0, halted}, 32'd0);
        check("hrst_cycles", stall_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
